// File: rtl/scpu_alu.sv
// Registered 32-bit integer ALU for the single-cycle CPU datapath.
// Ports: clk, rst (async high); a, b, alu_control in; alu_result, zero, cout, overflow out (registered).
module scpu_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_control,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    logic             inv_b;
    logic [WIDTH-1:0] b_add;
    logic [WIDTH:0]   sum;
    logic             ovf_raw;
    logic             lt;

    logic [WIDTH-1:0] result_d, result_q;
    logic             zero_d, zero_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;

    // One shared adder: anything other than ADD runs it as a - b so
    // SLT can reuse the subtract result and its overflow.
    assign inv_b   = (alu_control != OP_ADD);
    assign b_add   = inv_b ? ~b : b;
    assign sum     = {1'b0, a} + {1'b0, b_add} + {{WIDTH{1'b0}}, inv_b};
    assign ovf_raw = (a[WIDTH-1] == b_add[WIDTH-1]) &&
                     (sum[WIDTH-1] != a[WIDTH-1]);
    // Sign of a-b, corrected when the subtraction overflowed.
    assign lt      = sum[WIDTH-1] ^ ovf_raw;

    always_comb begin
        result_d = '0;
        cout_d   = 1'b0;
        ovf_d    = 1'b0;
        unique case (alu_control)
            OP_ADD: begin
                result_d = sum[WIDTH-1:0];
                cout_d   = sum[WIDTH];
                ovf_d    = ovf_raw;
            end
            OP_SUB: begin
                result_d = sum[WIDTH-1:0];
                cout_d   = sum[WIDTH];
                ovf_d    = ovf_raw;
            end
            OP_NOT: result_d = ~a;
            OP_AND: result_d = a & b;
            OP_OR:  result_d = a | b;
            OP_XOR: result_d = a ^ b;
            OP_SLT: result_d = {{(WIDTH-1){1'b0}}, lt};
            OP_EQ:  result_d = {{(WIDTH-1){1'b0}}, (a == b)};
            default: result_d = '0;
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign alu_result = result_q;
    assign zero       = zero_q;
    assign cout       = cout_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_scpu_alu.sv
// Scoreboard testbench for scpu_alu.
// Stimulus pushes expected responses; a monitor pops one per clock edge.
module tb_scpu_alu;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  alu_control;
    logic [31:0] alu_result;
    logic        zero;
    logic        cout;
    logic        overflow;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        o;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    scpu_alu #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .zero        (zero),
        .cout        (cout),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input exp_t e);
        checks++;
        if (alu_result !== e.res || zero !== e.z ||
            cout !== e.c || overflow !== e.o) begin
            errors++;
            $display("FAIL %s: got res=%h z=%b c=%b o=%b, want res=%h z=%b c=%b o=%b",
                     e.name, alu_result, zero, cout, overflow,
                     e.res, e.z, e.c, e.o);
        end
    endtask

    task automatic check_zero(input string name);
        exp_t e;
        e.res = 32'h0; e.z = 1'b0; e.c = 1'b0; e.o = 1'b0; e.name = name;
        check(e);
    endtask

    task automatic drive(input logic [2:0] ctl, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] res,
                         input logic z, input logic c, input logic o,
                         input string name);
        exp_t e;
        @(negedge clk);
        alu_control = ctl;
        a = va;
        b = vb;
        e.res = res; e.z = z; e.c = c; e.o = o; e.name = name;
        q.push_back(e);
    endtask

    // Monitor: the DUT presents a fresh result after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check(e);
            end
        end
    end

    initial begin
        rst = 1'b1;
        a = 32'd12;
        b = 32'd14;
        alu_control = 3'b000;
        #2;
        check_zero("reset_async");
        @(posedge clk);
        #1;
        check_zero("reset_held");

        @(negedge clk);
        rst = 1'b0;
        q.push_back('{32'd26, 1'b0, 1'b0, 1'b0, "add_12_14"});

        drive(3'b001, 32'd12, 32'd14, 32'hFFFFFFFE, 0, 0, 0, "sub_12_14");
        drive(3'b010, 32'd12, 32'd14, 32'hFFFFFFF3, 0, 0, 0, "not_12");
        drive(3'b011, 32'd12, 32'd14, 32'd12, 0, 0, 0, "and_12_14");
        drive(3'b100, 32'd12, 32'd14, 32'd14, 0, 0, 0, "or_12_14");
        drive(3'b101, 32'd12, 32'd14, 32'd2, 0, 0, 0, "xor_12_14");
        drive(3'b110, 32'd12, 32'd14, 32'd1, 0, 0, 0, "slt_12_14");
        drive(3'b111, 32'd12, 32'd14, 32'd0, 1, 0, 0, "eq_12_14");

        drive(3'b111, 32'd12, 32'd12, 32'd1, 0, 0, 0, "eq_12_12");
        drive(3'b110, 32'd12, 32'd12, 32'd0, 1, 0, 0, "slt_12_12");
        drive(3'b001, 32'd12, 32'd12, 32'd0, 1, 1, 0, "sub_12_12");

        drive(3'b000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 1, "add_ovf");
        drive(3'b000, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 1, 0, "add_carry");
        drive(3'b001, 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 1, 1, "sub_ovf");
        drive(3'b110, 32'h80000000, 32'h1, 32'h1, 0, 0, 0, "slt_ovf");
        drive(3'b110, 32'h1, 32'hFFFFFFFF, 32'h0, 1, 0, 0, "slt_pos_neg");
        drive(3'b101, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 0, 0, 0, "xor_pat");

        drive(3'b000, 32'd5, 32'd6, 32'd11, 0, 0, 0, "add_pre_rst");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_zero("rst_midstream");
        @(posedge clk);
        #1;
        check_zero("rst_mid_held");

        @(negedge clk);
        rst = 1'b0;
        drive(3'b011, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h05050505, 0, 0, 0, "and_post_rst");
        drive(3'b000, 32'h80000000, 32'h80000000, 32'h0, 1, 1, 1, "add_neg_ovf");

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
